// File: rtl/aplic_regif_initiator.sv
// Bus-master end of the APLIC 32-bit register interface: FIFO-buffered commands, in-order responses.
// Optional request timeout is compiled in when APLIC_REGIF_TIMEOUT_EN is defined.
module aplic_regif_initiator #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          i_clk,
    input  logic                          ni_rst,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]         i_cmd_addr,
    input  logic [31:0]                   i_cmd_wdata,
    input  logic [3:0]                    i_cmd_wstrb,
    output logic [ADDR_WIDTH-1:0]         o_req_addr,
    output logic                          o_req_write,
    output logic [31:0]                   o_req_wdata,
    output logic [3:0]                    o_req_wstrb,
    output logic                          o_req_valid,
    input  logic [31:0]                   i_resp_rdata,
    input  logic                          i_resp_error,
    input  logic                          i_resp_ready,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [31:0]                   o_rsp_rdata,
    output logic                          o_rsp_error,
    output logic                          o_rsp_timeout,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // state | meaning
    // IDLE  | waiting for a queued command; pops head into request registers
    // LOAD  | request fields settled, raise o_req_valid next edge
    // REQ   | request on the bus, waiting for i_resp_ready (or timeout)
    // RSP   | response held until i_rsp_ready
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_REQ, ST_RSP} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   fifo_addr_q  [FIFO_DEPTH];
    logic                    fifo_write_q [FIFO_DEPTH];
    logic [31:0]             fifo_wdata_q [FIFO_DEPTH];
    logic [3:0]              fifo_wstrb_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    push, pop;

    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic                    req_write_q;
    logic [31:0]             req_wdata_q;
    logic [3:0]              req_wstrb_q;
    logic                    req_valid_q;
    logic                    rsp_valid_q;
    logic [31:0]             rsp_rdata_q;
    logic                    rsp_error_q;

    assign push = i_cmd_valid && cmd_ready_q;
    assign pop  = (state_q == ST_IDLE) && (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        cmd_ready_d = (level_d < LVL_W'(FIFO_DEPTH));
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= i_cmd_addr;
            fifo_write_q[wr_ptr_q] <= i_cmd_write;
            fifo_wdata_q[wr_ptr_q] <= i_cmd_wdata;
            fifo_wstrb_q[wr_ptr_q] <= i_cmd_wstrb;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q     <= level_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

`ifdef APLIC_REGIF_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] tmo_cnt_q;
    logic            rsp_timeout_q;
    assign o_rsp_timeout = rsp_timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign o_rsp_timeout  = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q       <= ST_IDLE;
            req_addr_q    <= '0;
            req_write_q   <= 1'b0;
            req_wdata_q   <= '0;
            req_wstrb_q   <= '0;
            req_valid_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
`ifdef APLIC_REGIF_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (level_q != '0) begin
                        req_addr_q  <= fifo_addr_q[rd_ptr_q];
                        req_write_q <= fifo_write_q[rd_ptr_q];
                        // Reads never carry data or strobes onto the bus.
                        req_wdata_q <= fifo_write_q[rd_ptr_q] ? fifo_wdata_q[rd_ptr_q] : 32'h0;
                        req_wstrb_q <= fifo_write_q[rd_ptr_q] ? fifo_wstrb_q[rd_ptr_q] : 4'h0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    req_valid_q <= 1'b1;
`ifdef APLIC_REGIF_TIMEOUT_EN
                    tmo_cnt_q   <= '0;
`endif
                    state_q     <= ST_REQ;
                end
                ST_REQ: begin
                    if (i_resp_ready) begin
                        req_valid_q   <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= i_resp_error;
                        rsp_rdata_q   <= req_write_q ? 32'h0 : i_resp_rdata;
`ifdef APLIC_REGIF_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state_q       <= ST_RSP;
                    end
`ifdef APLIC_REGIF_TIMEOUT_EN
                    else if (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        req_valid_q   <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= 1'b1;
                        rsp_rdata_q   <= 32'h0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RSP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TO_W'(1);
                    end
`endif
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_req_addr   = req_addr_q;
    assign o_req_write  = req_write_q;
    assign o_req_wdata  = req_wdata_q;
    assign o_req_wstrb  = req_wstrb_q;
    assign o_req_valid  = req_valid_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_rsp_error  = rsp_error_q;
    assign o_busy       = (state_q != ST_IDLE) || (level_q != '0);
    assign o_fifo_level = level_q;

endmodule

// File: tb/tb_aplic_regif_initiator.sv
// Directed bench for aplic_regif_initiator; timeout step compiled only with APLIC_REGIF_TIMEOUT_EN.
module tb_aplic_regif_initiator;

    logic        i_clk = 1'b0;
    logic        ni_rst = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [31:0] i_cmd_addr = '0;
    logic [31:0] i_cmd_wdata = '0;
    logic [3:0]  i_cmd_wstrb = '0;
    logic [31:0] o_req_addr;
    logic        o_req_write;
    logic [31:0] o_req_wdata;
    logic [3:0]  o_req_wstrb;
    logic        o_req_valid;
    logic [31:0] i_resp_rdata = '0;
    logic        i_resp_error = 1'b0;
    logic        i_resp_ready = 1'b0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_error;
    logic        o_rsp_timeout;
    logic        o_busy;
    logic [2:0]  o_fifo_level;

    int errors = 0;
    int checks = 0;

    aplic_regif_initiator #(.FIFO_DEPTH(4), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(256)) dut (
        .i_clk(i_clk), .ni_rst(ni_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_req_addr(o_req_addr), .o_req_write(o_req_write), .o_req_wdata(o_req_wdata),
        .o_req_wstrb(o_req_wstrb), .o_req_valid(o_req_valid),
        .i_resp_rdata(i_resp_rdata), .i_resp_error(i_resp_error), .i_resp_ready(i_resp_ready),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_error(o_rsp_error), .o_rsp_timeout(o_rsp_timeout),
        .o_busy(o_busy), .o_fifo_level(o_fifo_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        i_cmd_valid = 1'b1;
        i_cmd_write = w;
        i_cmd_addr  = a;
        i_cmd_wdata = d;
        i_cmd_wstrb = s;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!o_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, o_req_valid}, 32'd1);
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        i_resp_ready = 1'b1;
        i_resp_rdata = rdata;
        i_resp_error = err;
        tick();
        i_resp_ready = 1'b0;
        i_resp_error = 1'b0;
        i_resp_rdata = '0;
    endtask

    task automatic consume();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
        chk("rst_req_valid", {31'b0, o_req_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_busy",      {31'b0, o_busy},      32'd0);
        chk("rst_level",     {29'b0, o_fifo_level}, 32'd0);
        ni_rst = 1'b1;
        chk("rel_cmd_ready_before_edge", {31'b0, o_cmd_ready}, 32'd0);
        tick();
        chk("rel_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);

        // write 0x4 <- 0x105, slave ready after 3 request cycles
        push(1'b1, 32'h4, 32'h105, 4'hF);
        chk("wr_level_k",     {29'b0, o_fifo_level}, 32'd1);
        chk("wr_valid_k",     {31'b0, o_req_valid}, 32'd0);
        chk("wr_busy_k",      {31'b0, o_busy}, 32'd1);
        tick();
        chk("wr_valid_k1",    {31'b0, o_req_valid}, 32'd0);
        chk("wr_level_k1",    {29'b0, o_fifo_level}, 32'd0);
        tick();
        chk("wr_valid_k2",    {31'b0, o_req_valid}, 32'd1);
        chk("wr_addr",        o_req_addr, 32'h4);
        chk("wr_write",       {31'b0, o_req_write}, 32'd1);
        chk("wr_wdata",       o_req_wdata, 32'h105);
        chk("wr_wstrb",       {28'b0, o_req_wstrb}, 32'hF);
        repeat (2) tick();
        chk("wr_valid_held",  {31'b0, o_req_valid}, 32'd1);
        chk("wr_wdata_held",  o_req_wdata, 32'h105);
        chk("wr_addr_held",   o_req_addr, 32'h4);
        respond(32'hDEAD_BEEF, 1'b0);
        chk("wr_req_drop",    {31'b0, o_req_valid}, 32'd0);
        chk("wr_rsp_valid",   {31'b0, o_rsp_valid}, 32'd1);
        chk("wr_rsp_rdata",   o_rsp_rdata, 32'h0);
        chk("wr_rsp_error",   {31'b0, o_rsp_error}, 32'd0);
        chk("wr_rsp_timeout", {31'b0, o_rsp_timeout}, 32'd0);
        tick();
        chk("wr_rsp_hold",    {31'b0, o_rsp_valid}, 32'd1);
        consume();
        chk("wr_rsp_done",    {31'b0, o_rsp_valid}, 32'd0);
        chk("wr_busy_done",   {31'b0, o_busy}, 32'd0);

        // read 0x0, zero-wait slave returns 0x8000_0000
        push(1'b0, 32'h0, 32'h1234_5678, 4'hF);
        wait_req("rd_req_valid");
        chk("rd_wstrb",       {28'b0, o_req_wstrb}, 32'h0);
        chk("rd_wdata",       o_req_wdata, 32'h0);
        chk("rd_write",       {31'b0, o_req_write}, 32'd0);
        chk("rd_addr",        o_req_addr, 32'h0);
        respond(32'h8000_0000, 1'b0);
        chk("rd_rsp_valid",   {31'b0, o_rsp_valid}, 32'd1);
        chk("rd_rsp_rdata",   o_rsp_rdata, 32'h8000_0000);
        chk("rd_rsp_error",   {31'b0, o_rsp_error}, 32'd0);
        respond(32'h1111_1111, 1'b1);
        chk("stray_ready_rdata", o_rsp_rdata, 32'h8000_0000);
        chk("stray_ready_error", {31'b0, o_rsp_error}, 32'd0);
        chk("stray_ready_req",   {31'b0, o_req_valid}, 32'd0);
        consume();

        // five back-to-back reads with the slave stalled: FIFO fills to 4
        for (int i = 0; i < 5; i++) begin
            i_cmd_valid = 1'b1;
            i_cmd_write = 1'b0;
            i_cmd_addr  = 32'h10 * (i + 1);
            i_cmd_wdata = '0;
            i_cmd_wstrb = '0;
            tick();
        end
        i_cmd_addr = 32'h60;
        chk("full_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
        chk("full_level",     {29'b0, o_fifo_level}, 32'd4);
        tick();
        i_cmd_valid = 1'b0;
        chk("full_level_blocked", {29'b0, o_fifo_level}, 32'd4);
        chk("full_head_addr",     o_req_addr, 32'h10);
        for (int i = 0; i < 5; i++) begin
            wait_req("ord_req_valid");
            chk("ord_addr", o_req_addr, 32'h10 * (i + 1));
            respond(32'hA000_0000 + i, 1'b0);
            chk("ord_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
            chk("ord_rsp_rdata", o_rsp_rdata, 32'hA000_0000 + i);
            consume();
        end
        tick();
        chk("drain_level", {29'b0, o_fifo_level}, 32'd0);
        chk("drain_busy",  {31'b0, o_busy}, 32'd0);
        chk("drain_ready", {31'b0, o_cmd_ready}, 32'd1);

        // slave error on a write, next command still issues
        push(1'b1, 32'h8, 32'h0000_CAFE, 4'h3);
        wait_req("err_req_valid");
        chk("err_wstrb", {28'b0, o_req_wstrb}, 32'h3);
        respond(32'h0, 1'b1);
        chk("err_rsp_error",   {31'b0, o_rsp_error}, 32'd1);
        chk("err_rsp_timeout", {31'b0, o_rsp_timeout}, 32'd0);
        chk("err_rsp_rdata",   o_rsp_rdata, 32'h0);
        consume();
        push(1'b0, 32'hC, 32'h0, 4'h0);
        wait_req("after_err_req_valid");
        chk("after_err_addr", o_req_addr, 32'hC);
        respond(32'h55, 1'b0);
        chk("after_err_error", {31'b0, o_rsp_error}, 32'd0);
        chk("after_err_rdata", o_rsp_rdata, 32'h55);
        consume();

`ifdef APLIC_REGIF_TIMEOUT_EN
        begin
            int n = 0;
            push(1'b0, 32'h20, 32'h0, 4'h0);
            wait_req("to_req_valid");
            while (o_req_valid && n < 300) begin
                tick();
                n++;
            end
            chk("to_cycles",      n, 32'd256);
            chk("to_rsp_valid",   {31'b0, o_rsp_valid}, 32'd1);
            chk("to_rsp_error",   {31'b0, o_rsp_error}, 32'd1);
            chk("to_rsp_timeout", {31'b0, o_rsp_timeout}, 32'd1);
            chk("to_rsp_rdata",   o_rsp_rdata, 32'h0);
            consume();
        end
`endif

        // reset while in REQ with two commands queued
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b1;
        i_cmd_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            i_cmd_addr  = 32'h30 + 4 * i;
            i_cmd_wdata = 32'h100 + i;
            tick();
        end
        i_cmd_valid = 1'b0;
        chk("prerst_req_valid", {31'b0, o_req_valid}, 32'd1);
        chk("prerst_level",     {29'b0, o_fifo_level}, 32'd2);
        #2;
        ni_rst = 1'b0;
        #1;
        chk("midrst_req_valid", {31'b0, o_req_valid}, 32'd0);
        chk("midrst_level",     {29'b0, o_fifo_level}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
        chk("midrst_busy",      {31'b0, o_busy}, 32'd0);
        tick();
        ni_rst = 1'b1;
        repeat (4) tick();
        chk("postrst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("postrst_req_valid", {31'b0, o_req_valid}, 32'd0);
        chk("postrst_level",     {29'b0, o_fifo_level}, 32'd0);
        chk("postrst_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
